// File: rtl/clk_div_ctrl.sv
// Programmable clock divider with a handshake-driven configuration port.
// Ratio changes and stops take effect at the next falling edge of newclk, so the output never glitches.
module clk_div_ctrl #(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned DEFAULT_HALF = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic             cfg_en,
    input  logic [WIDTH-1:0] cfg_div,
    output logic             newclk,
    output logic             tick,
    output logic             busy,
    output logic             cfg_err
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        PEND = 2'd1,
        STOP = 2'd2,
        IDLE = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] half;
    logic [WIDTH-1:0] half_nxt;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] pending_nxt;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_nxt;
    logic             newclk_nxt;
    logic             tick_nxt;
    logic             cfg_err_nxt;
    logic             xfer;
    logic             wrap;
    logic             div_zero;

    assign cfg_ready = !rst && ((state == RUN) || (state == IDLE));
    assign busy      = (state == PEND) || (state == STOP);
    assign xfer      = cfg_valid && cfg_ready;
    assign div_zero  = (cfg_div == '0);
    // half is never zero, so half-1 cannot underflow
    assign wrap      = (cnt == (half - WIDTH'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RUN;
            half    <= WIDTH'(DEFAULT_HALF);
            pending <= '0;
            cnt     <= '0;
            newclk  <= 1'b0;
            tick    <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            half    <= half_nxt;
            pending <= pending_nxt;
            cnt     <= cnt_nxt;
            newclk  <= newclk_nxt;
            tick    <= tick_nxt;
            cfg_err <= cfg_err_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        half_nxt    = half;
        pending_nxt = pending;
        cnt_nxt     = cnt;
        newclk_nxt  = newclk;
        cfg_err_nxt = 1'b0;

        // Free-running half-period counter; frozen in IDLE
        if (state != IDLE) begin
            if (wrap) begin
                cnt_nxt    = '0;
                newclk_nxt = !newclk;
            end else begin
                cnt_nxt = cnt + WIDTH'(1);
            end
        end

        case (state)
            RUN: begin
                if (xfer) begin
                    if (cfg_en && div_zero) begin
                        cfg_err_nxt = 1'b1;
                    end else if (cfg_en) begin
                        pending_nxt = cfg_div;
                        state_nxt   = PEND;
                    end else begin
                        state_nxt = STOP;
                    end
                end
            end
            PEND: begin
                if (wrap && newclk) begin
                    half_nxt  = pending;
                    state_nxt = RUN;
                end
            end
            STOP: begin
                if (wrap && newclk) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                cnt_nxt    = '0;
                newclk_nxt = 1'b0;
                if (xfer && cfg_en) begin
                    if (div_zero) begin
                        cfg_err_nxt = 1'b1;
                    end else begin
                        half_nxt  = cfg_div;
                        state_nxt = RUN;
                    end
                end
            end
            default: state_nxt = RUN;
        endcase

        tick_nxt = newclk_nxt && !newclk;
    end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: directed scenarios plus random traffic
// compared against an absolute-time toggle schedule model.
module tb_clk_div_ctrl;

    localparam int unsigned W   = 16;
    localparam int unsigned DEF = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic         cfg_valid;
    logic         cfg_ready;
    logic         cfg_en;
    logic [W-1:0] cfg_div;
    logic         newclk;
    logic         tick;
    logic         busy;
    logic         cfg_err;

    int n_vec = 0;
    int n_err = 0;

    // Model: level plus the absolute edge index of the next toggle
    int           m_edge  = 0;
    int           m_next  = 0;
    int           m_half  = DEF;
    bit           m_level = 1'b0;
    bit           m_tick  = 1'b0;
    bit           m_err   = 1'b0;
    bit           m_pend  = 1'b0;
    bit           m_stop  = 1'b0;
    bit           m_idle  = 1'b0;
    int           m_pval  = 0;

    clk_div_ctrl #(.WIDTH(W), .DEFAULT_HALF(DEF)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_en    (cfg_en),
        .cfg_div   (cfg_div),
        .newclk    (newclk),
        .tick      (tick),
        .busy      (busy),
        .cfg_err   (cfg_err)
    );

    always #5 clk = !clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic void model_edge(input bit r, input bit x, input bit en, input int d);
        m_edge++;
        m_tick = 1'b0;
        m_err  = 1'b0;
        if (r) begin
            m_level = 1'b0;
            m_half  = DEF;
            m_next  = m_edge + DEF;
            m_pend  = 1'b0;
            m_stop  = 1'b0;
            m_idle  = 1'b0;
            return;
        end
        // Scheduled toggle first: a request accepted on this edge cannot use this fall
        if (!m_idle && m_edge == m_next) begin
            m_level = !m_level;
            m_tick  = m_level;
            if (!m_level && m_pend) begin
                m_half = m_pval;
                m_pend = 1'b0;
            end
            if (!m_level && m_stop) begin
                m_idle = 1'b1;
                m_stop = 1'b0;
            end
            m_next = m_edge + m_half;
        end
        if (x) begin
            if (en && d == 0) begin
                m_err = 1'b1;
            end else if (en && m_idle) begin
                m_idle = 1'b0;
                m_half = d;
                m_next = m_edge + d;
            end else if (en) begin
                m_pend = 1'b1;
                m_pval = d;
            end else if (!m_idle) begin
                m_stop = 1'b1;
            end
        end
    endfunction

    task automatic cycle(input bit r, input bit v, input bit en, input logic [W-1:0] d);
        bit exp_ready;
        @(negedge clk);
        rst       = r;
        cfg_valid = v;
        cfg_en    = en;
        cfg_div   = d;
        #1;
        exp_ready = !r && !(m_pend || m_stop);
        check_eq("cfg_ready", 32'(cfg_ready), 32'(exp_ready));
        model_edge(r, v && exp_ready, en, int'(d));
        @(posedge clk);
        #1;
        check_eq("newclk",  32'(newclk),  32'(m_level));
        check_eq("tick",    32'(tick),    32'(m_tick));
        check_eq("busy",    32'(busy),    32'(m_pend || m_stop));
        check_eq("cfg_err", 32'(cfg_err), 32'(m_err));
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, '0);
    endtask

    // Cycles until newclk reads high, bounded
    task automatic cycles_to_rise(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(1'b0, 1'b0, 1'b0, '0);
            n++;
            if (newclk) break;
        end
        check_eq("rise_timeout", 32'(newclk), 32'd1);
    endtask

    task automatic wait_low;
        for (int i = 0; i < 40 && newclk; i++) cycle(1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic wait_not_busy;
        for (int i = 0; i < 60 && busy; i++) cycle(1'b0, 1'b0, 1'b0, '0);
        check_eq("busy_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1; cfg_valid = 1'b0; cfg_en = 1'b0; cfg_div = '0;

        // Reset then free run: first rise 5 edges after release, period 10
        cycle(1'b1, 1'b0, 1'b0, '0);
        cycle(1'b1, 1'b1, 1'b1, 16'd9);
        cycles_to_rise(n);
        check_eq("first_rise", 32'(n), 32'd5);
        wait_low;
        cycles_to_rise(n);
        check_eq("rise_to_rise", 32'(n + 5), 32'd10);
        idle_cycles(22);

        // Ratio change to 3, requested during a high phase
        wait_low;
        cycles_to_rise(n);
        cycle(1'b0, 1'b1, 1'b1, 16'd3);
        idle_cycles(30);

        // Illegal request: error pulse only
        cycle(1'b0, 1'b1, 1'b1, 16'd0);
        idle_cycles(15);

        // Stop, sit idle, restart with half=2
        cycle(1'b0, 1'b1, 1'b0, 16'd123);
        wait_not_busy;
        idle_cycles(12);
        cycle(1'b0, 1'b1, 1'b0, 16'd44);
        cycle(1'b0, 1'b1, 1'b1, 16'd0);
        cycle(1'b0, 1'b1, 1'b1, 16'd2);
        cycles_to_rise(n);
        check_eq("restart_rise", 32'(n), 32'd2);
        idle_cycles(12);

        // Backpressure: request held while the first one is pending
        cycle(1'b0, 1'b1, 1'b1, 16'd4);
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, 1'b1, 16'd6);
        idle_cycles(30);

        // Reset while pending=7: aborts, back to period 10
        cycle(1'b0, 1'b1, 1'b1, 16'd7);
        cycle(1'b0, 1'b0, 1'b0, '0);
        check_eq("pend_before_rst", 32'(busy), 32'd1);
        cycle(1'b1, 1'b0, 1'b0, '0);
        check_eq("rst_newclk", 32'(newclk), 32'd0);
        check_eq("rst_busy",   32'(busy),   32'd0);
        cycles_to_rise(n);
        check_eq("rst_first_rise", 32'(n), 32'd5);
        wait_low;
        cycles_to_rise(n);
        check_eq("period_after_rst", 32'(n + 5), 32'd10);

        // Half of 1 from idle, then all-ones (no rise within a short window)
        cycle(1'b0, 1'b1, 1'b0, '0);
        wait_not_busy;
        cycle(1'b0, 1'b1, 1'b1, 16'd1);
        idle_cycles(8);
        cycle(1'b0, 1'b1, 1'b0, '0);
        wait_not_busy;
        cycle(1'b0, 1'b1, 1'b1, 16'hFFFF);
        idle_cycles(25);
        cycle(1'b1, 1'b0, 1'b0, '0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bit r;
            bit v;
            bit en;
            logic [W-1:0] d;
            r  = ($urandom_range(0, 199) == 0);
            v  = ($urandom_range(0, 7) == 0);
            en = ($urandom_range(0, 7) != 0);
            d  = W'($urandom_range(0, 6));
            cycle(r, v, en, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
